// File: rtl/control_unit.sv
// Multi-cycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/memory/write-back.
// Define CONTROL_ILLEGAL_TRAP_EN to trap on unrecognised opcodes (otherwise they execute as a NOP).
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_source_o,
    output logic       ir_write_o,
    output logic       addr_sel_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] ALU_CO_o,
    output logic       is_immediate_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
`ifdef CONTROL_ILLEGAL_TRAP_EN
        , S_TRAP   = 4'd13
`endif
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_co;
        logic       is_immediate;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // NOTE: a default assignment before the case keeps this purely combinational (no latch).
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
            S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALUWB;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.addr_sel = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = 2'b01;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.addr_sel  = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_co    = 2'b10;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a    = 2'b01;
                ctrl.alu_src_b    = 2'b10;
                ctrl.alu_co       = 2'b10;
                ctrl.is_immediate = 1'b1;
            end
            S_ALUWB:  ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 2'b01;
                ctrl.alu_co        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = 2'b10;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b01;
            end
            S_JALR: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = 2'b10;
                ctrl.pc_write  = 1'b1;
            end
            S_LUI: begin
                ctrl.alu_src_a = 2'b11;
                ctrl.alu_src_b = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset holds the FSM in FETCH, whose read strobe must not reach memory during reset.
    assign ctrl_out = rst_n ? ctrl : '0;

    assign pc_write_o      = ctrl_out.pc_write;
    assign pc_write_cond_o = ctrl_out.pc_write_cond;
    assign pc_source_o     = ctrl_out.pc_source;
    assign ir_write_o      = ctrl_out.ir_write;
    assign addr_sel_o      = ctrl_out.addr_sel;
    assign mem_read_o      = ctrl_out.mem_read;
    assign mem_write_o     = ctrl_out.mem_write;
    assign reg_write_o     = ctrl_out.reg_write;
    assign wb_sel_o        = ctrl_out.wb_sel;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign ALU_CO_o        = ctrl_out.alu_co;
    assign is_immediate_o  = ctrl_out.is_immediate;
    assign state_o         = state_q;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    assign illegal_o = (state_q == S_TRAP);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: route-based reference model, per-cycle output compare,
// directed sequences from hand-derived state traces, then randomized opcodes, stalls and resets.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_cond_o, ir_write_o, addr_sel_o;
    logic       mem_read_o, mem_write_o, reg_write_o, is_immediate_o, illegal_o;
    logic [1:0] pc_source_o, wb_sel_o, alu_src_a_o, alu_src_b_o, ALU_CO_o;
    logic [3:0] state_o;

    control_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_i        (opcode_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .pc_source_o     (pc_source_o),
        .ir_write_o      (ir_write_o),
        .addr_sel_o      (addr_sel_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .reg_write_o     (reg_write_o),
        .wb_sel_o        (wb_sel_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .ALU_CO_o        (ALU_CO_o),
        .is_immediate_o  (is_immediate_o),
        .state_o         (state_o),
        .illegal_o       (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit layout: state[22:19] pc_write[18] pc_write_cond[17] pc_source[16:15] ir_write[14]
    // addr_sel[13] mem_read[12] mem_write[11] reg_write[10] wb_sel[9:8] a[7:6] b[5:4] co[3:2] imm[1] ill[0]
    function automatic logic [22:0] dut_vec();
        return {state_o, pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, addr_sel_o,
                mem_read_o, mem_write_o, reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o,
                ALU_CO_o, is_immediate_o, illegal_o};
    endfunction

    function automatic logic [22:0] exp_vec(input int s, input logic rdy, input logic rst_ok);
        logic       pw, pwc, irw, as, mr, mw, rw, imm, ill;
        logic [1:0] ps, wb, a, b, co;
        {pw, pwc, irw, as, mr, mw, rw, imm, ill} = '0;
        {ps, wb, a, b, co} = '0;
        if (rst_ok) begin
            case (s)
                0:  begin mr = 1; b = 2'b01; irw = rdy; pw = rdy; end
                1:  begin a = 2'b10; b = 2'b10; end
                2:  begin a = 2'b01; b = 2'b10; end
                3:  begin mr = 1; as = 1; end
                4:  begin rw = 1; wb = 2'b01; end
                5:  begin mw = 1; as = 1; end
                6:  begin a = 2'b01; co = 2'b10; end
                7:  begin a = 2'b01; b = 2'b10; co = 2'b10; imm = 1; end
                8:  rw = 1;
                9:  begin a = 2'b01; co = 2'b01; pwc = 1; ps = 2'b01; end
                10: begin rw = 1; wb = 2'b10; pw = 1; ps = 2'b01; end
                11: begin a = 2'b01; b = 2'b10; rw = 1; wb = 2'b10; pw = 1; end
                12: begin a = 2'b11; b = 2'b10; end
                13: ill = 1;
                default: ;
            endcase
        end
        return {(rst_ok ? 4'(s) : 4'd0), pw, pwc, ps, irw, as, mr, mw, rw, wb, a, b, co, imm, ill};
    endfunction

    // Reference model: after DECODE each instruction class follows a fixed route of states,
    // stalling only in the memory-handshake states while mem_ready_i is low.
    int exp_state = 0;
    int route[$];

    function automatic void load_route(input logic [6:0] op);
        logic [15:0] r;
        case (op)
            7'b0000011: r = 16'h0234;
            7'b0100011: r = 16'h0025;
            7'b0110011: r = 16'h0068;
            7'b0010011: r = 16'h0078;
            7'b1100011: r = 16'h0009;
            7'b1101111: r = 16'h000A;
            7'b1100111: r = 16'h000B;
            7'b0110111: r = 16'h00C8;
            7'b0010111: r = 16'h0008;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            default:    r = 16'h000D;
`else
            default:    r = 16'h0000;
`endif
        endcase
        route.delete();
        for (int k = 3; k >= 0; k--)
            if (r[4*k +: 4] != 4'd0) route.push_back(int'(r[4*k +: 4]));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_state = 0;
                route.delete();
            end else if (exp_state == 13) begin
                exp_state = 13;
            end else if ((exp_state == 0 || exp_state == 3 || exp_state == 5) && !mem_ready_i) begin
                exp_state = exp_state;
            end else if (exp_state == 0) begin
                exp_state = 1;
            end else begin
                if (exp_state == 1) load_route(opcode_i);
                if (route.size() == 0) exp_state = 0;
                else exp_state = route.pop_front();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle_outputs", 32'(dut_vec()), 32'(exp_vec(exp_state, mem_ready_i, rst_n)));
        end
    end

    logic [22:0] cap_vec [16];

    task automatic run_seq(input string name, input logic [6:0] op, input logic [15:0] rdy,
                           input logic [63:0] seq, input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            opcode_i    = op;
            mem_ready_i = rdy[len-1-i];
            @(negedge clk);
            cap_vec[i] = dut_vec();
            check(name, 32'(cap_vec[i][22:19]), 32'(seq[4*(len-1-i) +: 4]));
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 10))
            0:  return 7'b0000011;
            1:  return 7'b0100011;
            2:  return 7'b0110011;
            3:  return 7'b0010011;
            4:  return 7'b1100011;
            5:  return 7'b1101111;
            6:  return 7'b1100111;
            7:  return 7'b0110111;
            8:  return 7'b0010111;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        logic [6:0] cur_op;
        int         rst_hold;
        int         trap_cycles;
        rst_n       = 1'b0;
        opcode_i    = 7'd0;
        mem_ready_i = 1'b0;
        cur_op      = 7'd0;
        rst_hold    = 0;
        trap_cycles = 0;

        repeat (3) @(negedge clk);
        check("reset_all_zero", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch_state", 32'(state_o), 32'd0);
        check("first_fetch_read", 32'(mem_read_o), 32'd1);

        // Load stalled in MEMREAD, then reset mid-access.
        run_seq("lw_pre_reset", 7'b0000011, 16'b1110, 64'h0123, 4);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_memread", 32'(dut_vec()), 32'd0);
        mem_ready_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_state", 32'(state_o), 32'd0);
        check("rel_mem_read", 32'(mem_read_o), 32'd1);

        run_seq("r_type_seq", 7'b0110011, 16'b1000, 64'h0168, 4);
        check("r_type_co", 32'(cap_vec[2][3:2]), 32'd2);
        check("r_type_imm", 32'(cap_vec[2][1]), 32'd0);
        for (int i = 0; i < 4; i++) check("r_type_regwrite", 32'(cap_vec[i][10]), 32'(i == 3));

        run_seq("lw_wait_seq", 7'b0000011, 16'b1110010, 64'h0123334, 7);
        for (int i = 3; i < 6; i++) begin
            check("lw_memread", 32'(cap_vec[i][12]), 32'd1);
            check("lw_addrsel", 32'(cap_vec[i][13]), 32'd1);
        end
        check("lw_wbsel", 32'(cap_vec[6][9:8]), 32'd1);

        run_seq("branch_seq", 7'b1100011, 16'b100, 64'h019, 3);
        check("branch_co", 32'(cap_vec[2][3:2]), 32'd1);
        check("branch_pwc", 32'(cap_vec[2][17]), 32'd1);
        check("branch_pw", 32'(cap_vec[2][18]), 32'd0);

        run_seq("jal_seq", 7'b1101111, 16'b111, 64'h01A, 3);
        check("jal_pw", 32'(cap_vec[2][18]), 32'd1);
        check("jal_ps", 32'(cap_vec[2][16:15]), 32'd1);
        check("jal_wb", 32'(cap_vec[2][9:8]), 32'd2);

        run_seq("auipc_seq", 7'b0010111, 16'b100, 64'h018, 3);
        run_seq("sw_seq", 7'b0100011, 16'b1001, 64'h0125, 4);
        check("sw_memwrite", 32'(cap_vec[3][11]), 32'd1);
        run_seq("fetch_wait_lui", 7'b0110111, 16'b001000, 64'h0001C8, 6);
        check("fetch_wait_irw0", 32'(cap_vec[0][14]), 32'd0);
        check("fetch_wait_irw1", 32'(cap_vec[2][14]), 32'd1);

`ifdef CONTROL_ILLEGAL_TRAP_EN
        run_seq("illegal_trap_seq", 7'b1111111, 16'b100, 64'h01D, 3);
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
            check("trap_state", 32'(state_o), 32'd13);
            check("trap_illegal", 32'(illegal_o), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("trap_recover", 32'(state_o), 32'd0);
`else
        run_seq("illegal_nop_seq", 7'b1111111, 16'b10, 64'h01, 2);
        check("illegal_nop_flag", 32'(cap_vec[1][0]), 32'd0);
        idle_cycle();
        check("illegal_nop_back", 32'(state_o), 32'd0);
        check("illegal_nop_ill", 32'(illegal_o), 32'd0);
`endif

        // Randomized phase: opcodes only valid where sampled, random stalls and resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                if (rst_hold == 0) rst_n = 1'b1;
                else rst_hold--;
            end else if ($urandom_range(0, 199) == 0 || trap_cycles > 12) begin
                rst_n       = 1'b0;
                rst_hold    = $urandom_range(0, 2);
                trap_cycles = 0;
            end
            if (exp_state == 13) trap_cycles++;
            if (exp_state == 0) cur_op = pick_op();
            opcode_i    = (exp_state == 1 || exp_state == 2) ? cur_op : 7'($urandom);
            mem_ready_i = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle main controller for the RV32I core: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It decodes the instruction opcode and drives the datapath muxes, register/PC/IR write enables and memory strobes. It also produces the 2-bit ALU class code and immediate flag consumed directly by the downstream ALU control decoder. Memory accesses use a ready handshake, so the core stalls on slow memory.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode_i  in  7  instr[6:0] from the instruction register
- mem_ready_i  in  1  memory completes the current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if the datapath branch condition is true
- pc_source_o  out  2  00 ALU result, 01 ALUOut register
- ir_write_o  out  1  instruction register load
- addr_sel_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- reg_write_o  out  1  register file write
- wb_sel_o  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC
- alu_src_a_o  out  2  00 PC, 01 rs1, 10 old PC, 11 zero
- alu_src_b_o  out  2  00 rs2, 01 constant 4, 10 immediate
- ALU_CO_o  out  2  00 add, 01 branch, 10 funct-decoded
- is_immediate_o  out  1  1 for OP-IMM execute
- state_o  out  4  current state code
- illegal_o  out  1  trap indicator; constant 0 unless CONTROL_ILLEGAL_TRAP_EN is defined

## Operation
- Outputs are decoded from state only, except `ir_write_o` and `pc_write_o` in FETCH, which equal `mem_ready_i`.
- Every output not listed for a state is 0.
- States, with code, outputs and next state:
  - FETCH(0): mem_read, addr_sel=0, a=00, b=01, CO=00. Holds until `mem_ready_i`, then goes to DECODE.
  - DECODE(1): a=10, b=10, CO=00, so ALUOut = old PC + imm. Next state is chosen by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> ALUWB (AUIPC; the result is already in ALUOut)
    - any other opcode -> illegal handling
  - MEMADR(2): a=01, b=10, CO=00. Next is MEMREAD if `opcode_i[5]`=0, else MEMWRITE.
  - MEMREAD(3): mem_read, addr_sel=1. Holds until `mem_ready_i`, then goes to MEMWB.
  - MEMWB(4): reg_write, wb_sel=01. Next is FETCH.
  - MEMWRITE(5): mem_write, addr_sel=1. Holds until `mem_ready_i`, then goes to FETCH.
  - EXEC_R(6): a=01, b=00, CO=10, is_immediate=0. Next is ALUWB.
  - EXEC_I(7): a=01, b=10, CO=10, is_immediate=1. Next is ALUWB.
  - ALUWB(8): reg_write, wb_sel=00. Next is FETCH.
  - BRANCH(9): a=01, b=00, CO=01, pc_write_cond, pc_source=01. Next is FETCH.
  - JAL(10): reg_write, wb_sel=10, pc_write, pc_source=01. Next is FETCH.
  - JALR(11): a=01, b=10, CO=00, reg_write, wb_sel=10, pc_write, pc_source=00. Next is FETCH.
  - LUI(12): a=11, b=10, CO=00. Next is ALUWB.
  - TRAP(13): illegal_o=1. Terminal state; only reset leaves it.
- The PC is already PC+4 after FETCH, so wb_sel=10 writes the correct link address.
- `opcode_i` is sampled only in DECODE and MEMADR.
- Unused state codes 14 and 15 go to FETCH on the next edge with all outputs 0.

## Timing
- Reset:
  - Asynchronous assert forces state=FETCH.
  - While `rst_n`=0, all outputs are 0, including `mem_read_o`; `illegal_o` is 0.
  - The first FETCH cycle is the first rising edge after deassertion.
- Reset asserted in any state, including mid-memory-access or TRAP, returns to FETCH immediately with no completion of the pending access.
- Cycle counts with zero wait states (`mem_ready_i`=1 on the first strobe cycle):

| Instruction | Cycles |
|---|---|
| LW | 5 |
| SW | 4 |
| R-type, OP-IMM, LUI | 4 |
| AUIPC, BRANCH, JAL, JALR | 3 |

- Each cycle with `mem_ready_i`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. The strobes stay asserted and stable throughout.
- `mem_ready_i` outside FETCH, MEMREAD and MEMWRITE is ignored.

## Configuration
- CONTROL_ILLEGAL_TRAP_EN defined: an unrecognised opcode in DECODE goes to TRAP. `illegal_o`=1 and all other outputs are 0 until reset.
- CONTROL_ILLEGAL_TRAP_EN undefined:
  - An unrecognised opcode in DECODE returns to FETCH and executes as a 2-cycle NOP.
  - The TRAP state is not compiled.
  - `illegal_o` is tied to 0.

## Test plan
- Reset mid-MEMREAD (state_o=3):
  - While `rst_n`=0: all outputs are 0.
  - After release: state_o=0 and mem_read_o=1.
- opcode 0110011, `mem_ready_i`=1: state sequence 0,1,6,8,0; ALU_CO_o=10 with is_immediate_o=0 in state 6; reg_write_o=1 only in state 8.
- opcode 0000011, `mem_ready_i` low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0 (7 cycles); mem_read_o=1 and addr_sel_o=1 throughout state 3; wb_sel_o=01 in state 4.
- opcode 1100011: sequence 0,1,9,0; ALU_CO_o=01 and pc_write_cond_o=1 in state 9; pc_write_o=0 there.
- opcode 1101111: state 10 has pc_write_o=1, pc_source_o=01, wb_sel_o=10. Opcode 0010111: sequence 0,1,8,0.
- opcode 1111111:
  - With CONTROL_ILLEGAL_TRAP_EN: state_o=13, illegal_o=1, held for more than 10 cycles; reset recovers to state 0.
  - Without it: sequence 0,1,0 and illegal_o stays 0.
